riscv_v_csr: RTL and testbench

- Vector CSR register file. Sits directly downstream of the vector CSR write-control stage and consumes its WB-stage write enables and write data.
- Holds vtype, vl, vstart, vxrm, vxsat and the vsstatus VS field.
- Legalizes writes, applies hardware side effects (vstart clear, sticky vxsat, VS dirty tracking) and presents current values to decode/execute.

---
 rtl/riscv_v_pkg.sv | 65 ++++++
 rtl/riscv_v_csr_if.sv | 44 ++++
 rtl/riscv_v_csr_vs_fsm.sv | 49 ++++
 rtl/riscv_v_csr.sv | 158 +++++++++++++++
 tb/tb_riscv_v_csr.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_v_pkg.sv
// -----------------------------------------------------------------------------
// riscv_v_pkg
// Shared types, constants and helpers for the vector CSR register file.
//   riscv_v_vtype_t     : {vill, reserved, vma, vta, vsew[2:0], vlmul[2:0]}
//   riscv_v_vl_t        : log2(VLEN)+1 bits, so vl can hold VLMAX itself
//   riscv_v_vstart_t    : log2(VLEN) bits
//   riscv_v_vsstatus_t  : XLEN-wide view; only VS at [10:9] is meaningful
//   riscv_v_vs_state_e  : VS field encoding (OFF, INITIAL, CLEAN, DIRTY)
//   riscv_v_vtype_legal : vtype legality check against a given ELEN
// -----------------------------------------------------------------------------
package riscv_v_pkg;

    localparam int RISCV_V_XLEN     = 32;
    localparam int RISCV_V_VLEN     = 128;
    localparam int RISCV_V_ELEN     = 32;
    localparam int RISCV_V_VL_W     = $clog2(RISCV_V_VLEN) + 1;
    localparam int RISCV_V_VSTART_W = $clog2(RISCV_V_VLEN);
    localparam int RISCV_V_VS_LSB   = 9;

    typedef struct packed {
        logic                     vill;
        logic [RISCV_V_XLEN-10:0] reserved;
        logic                     vma;
        logic                     vta;
        logic [2:0]               vsew;
        logic [2:0]               vlmul;
    } riscv_v_vtype_t;

    typedef logic [RISCV_V_VL_W-1:0]     riscv_v_vl_t;
    typedef logic [RISCV_V_VSTART_W-1:0] riscv_v_vstart_t;
    typedef logic [RISCV_V_XLEN-1:0]     riscv_v_vsstatus_t;

    typedef enum logic [1:0] {
        OFF     = 2'b00,
        INITIAL = 2'b01,
        CLEAN   = 2'b10,
        DIRTY   = 2'b11
    } riscv_v_vs_state_e;

    localparam riscv_v_vtype_t RISCV_V_VTYPE_RST = '{vill: 1'b1, default: '0};

    // A vtype is illegal when reserved bits are set, vlmul is the reserved
    // encoding 100, SEW exceeds ELEN, or SEW exceeds ELEN*LMUL for the
    // fractional encodings (101=1/8, 110=1/4, 111=1/2).
    function automatic logic riscv_v_vtype_legal(riscv_v_vtype_t vtype, int elen);
        logic [31:0] sew;
        logic [31:0] elen_u;
        logic [2:0]  frac_shamt;
        logic        illegal;
        sew        = 32'd8 << vtype.vsew;
        elen_u     = 32'(elen);
        frac_shamt = 3'd4 - {1'b0, vtype.vlmul[1:0]};
        illegal    = (|vtype.reserved) || (vtype.vlmul == 3'b100) || (sew > elen_u);
        if (vtype.vlmul[2] && (vtype.vlmul[1:0] != 2'b00) && (sew > (elen_u >> frac_shamt))) begin
            illegal = 1'b1;
        end
        return !illegal;
    endfunction

    // Place the VS field into its vsstatus bit position; other bits read 0.
    function automatic riscv_v_vsstatus_t riscv_v_vsstatus_pack(riscv_v_vs_state_e vs);
        return riscv_v_vsstatus_t'({vs}) << RISCV_V_VS_LSB;
    endfunction

endpackage

// File: rtl/riscv_v_csr_if.sv
// -----------------------------------------------------------------------------
// riscv_v_csr_if
// WB-stage write bus from the vector CSR write-control stage into the vector
// CSR register file: per-CSR write enables and data plus the three hardware
// side-effect events (vstart clear, vxsat set, vector register write).
//   master : write-control stage (drives everything)
//   slave  : riscv_v_csr (samples everything)
// -----------------------------------------------------------------------------
interface riscv_v_csr_if;
    import riscv_v_pkg::*;

    logic              csr_wr_en_vsstatus_wb;
    logic              csr_wr_en_vtype_wb;
    logic              csr_wr_en_vl_wb;
    logic              csr_wr_en_vstart_wb;
    logic              csr_wr_en_vxrm_wb;
    logic              csr_wr_en_vxsat_wb;
    riscv_v_vsstatus_t csr_wr_data_vsstatus_wb;
    riscv_v_vtype_t    csr_wr_data_vtype_wb;
    riscv_v_vl_t       csr_wr_data_vl_wb;
    riscv_v_vstart_t   csr_wr_data_vstart_wb;
    logic [1:0]        csr_wr_data_vxrm_wb;
    logic              csr_wr_data_vxsat_wb;
    logic              vstart_clr_wb;
    logic              vxsat_set_wb;
    logic              vreg_wr_wb;

    modport master (
        output csr_wr_en_vsstatus_wb, csr_wr_en_vtype_wb, csr_wr_en_vl_wb,
               csr_wr_en_vstart_wb, csr_wr_en_vxrm_wb, csr_wr_en_vxsat_wb,
               csr_wr_data_vsstatus_wb, csr_wr_data_vtype_wb, csr_wr_data_vl_wb,
               csr_wr_data_vstart_wb, csr_wr_data_vxrm_wb, csr_wr_data_vxsat_wb,
               vstart_clr_wb, vxsat_set_wb, vreg_wr_wb
    );

    modport slave (
        input  csr_wr_en_vsstatus_wb, csr_wr_en_vtype_wb, csr_wr_en_vl_wb,
               csr_wr_en_vstart_wb, csr_wr_en_vxrm_wb, csr_wr_en_vxsat_wb,
               csr_wr_data_vsstatus_wb, csr_wr_data_vtype_wb, csr_wr_data_vl_wb,
               csr_wr_data_vstart_wb, csr_wr_data_vxrm_wb, csr_wr_data_vxsat_wb,
               vstart_clr_wb, vxsat_set_wb, vreg_wr_wb
    );

endinterface

// File: rtl/riscv_v_csr_vs_fsm.sv
// -----------------------------------------------------------------------------
// riscv_v_csr_vs_fsm
// vsstatus.VS state register. An explicit load wins over a dirtying event;
// a dirtying event moves any enabled state to DIRTY, while OFF stays OFF.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (-> INITIAL)
//   load_en   : explicit vsstatus write
//   load_val  : VS value to load
//   dirty_ev  : vector state was modified this cycle
//   state     : current VS state (registered)
// -----------------------------------------------------------------------------
module riscv_v_csr_vs_fsm
    import riscv_v_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  riscv_v_vs_state_e load_val,
    input  logic              dirty_ev,
    output riscv_v_vs_state_e state
);

    riscv_v_vs_state_e state_q;
    riscv_v_vs_state_e state_d;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INITIAL;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the default assignment first guarantees state_d is written on
    // every path, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (load_en) begin
            state_d = load_val;
        end else if (dirty_ev && (state_q != OFF)) begin
            state_d = DIRTY;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/riscv_v_csr.sv
// -----------------------------------------------------------------------------
// riscv_v_csr
// Vector CSR register file: vtype, vl, vstart, vxrm, vxsat and vsstatus.VS.
// Legalizes WB-stage writes and applies hardware side effects (vstart clear,
// sticky vxsat, VS dirty tracking). Outputs are registered; a write shows up
// the cycle after its enable.
// Optional: define RISCV_V_CSR_WB_BYPASS_EN to forward legalized WB write data
// to the outputs in the same cycle as the enable.
// Parameters:
//   VLEN : vector register length in bits (VLMAX_ABS = VLEN/8); must match
//          the widths of the package types
//   ELEN : maximum element width used for vtype legality
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   wb            : WB write bus (riscv_v_csr_if.slave)
//   csr_vsstatus  : vsstatus view, VS at [10:9]
//   csr_vtype, csr_vl, csr_vstart, csr_vxrm, csr_vxsat : current values
//   csr_vcsr      : {vxrm, vxsat}
//   vs_off        : VS == OFF
// -----------------------------------------------------------------------------
module riscv_v_csr
    import riscv_v_pkg::*;
#(
    parameter int VLEN = RISCV_V_VLEN,
    parameter int ELEN = RISCV_V_ELEN
) (
    input  logic               clk,
    input  logic               rst,
    riscv_v_csr_if.slave       wb,
    output riscv_v_vsstatus_t  csr_vsstatus,
    output riscv_v_vtype_t     csr_vtype,
    output riscv_v_vl_t        csr_vl,
    output riscv_v_vstart_t    csr_vstart,
    output logic [1:0]         csr_vxrm,
    output logic               csr_vxsat,
    output logic [2:0]         csr_vcsr,
    output logic               vs_off
);

    localparam riscv_v_vl_t VLMAX_ABS = riscv_v_vl_t'(VLEN / 8);

    riscv_v_vtype_t    vtype_q;
    riscv_v_vl_t       vl_q;
    riscv_v_vstart_t   vstart_q;
    logic [1:0]        vxrm_q;
    logic              vxsat_q;

    logic              vtype_legal;
    riscv_v_vtype_t    vtype_wr_val;
    riscv_v_vl_t       vl_wr_val;
    logic              vl_force_zero;
    logic              dirty_ev;
    riscv_v_vs_state_e vs_load_val;
    riscv_v_vs_state_e vs_state;
    riscv_v_vs_state_e vs_cur;

    // Only VS is implemented in vsstatus, and the written vill bit is
    // recomputed from legality, so these write-data bits are don't-care.
    logic unused_wb_bits;
    assign unused_wb_bits = ^{wb.csr_wr_data_vsstatus_wb[RISCV_V_XLEN-1:RISCV_V_VS_LSB+2],
                              wb.csr_wr_data_vsstatus_wb[RISCV_V_VS_LSB-1:0],
                              wb.csr_wr_data_vtype_wb.vill};

    // ---------------------------------------------------------------- legalize
    assign vtype_legal = riscv_v_vtype_legal(wb.csr_wr_data_vtype_wb, ELEN);

    always_comb begin
        vtype_wr_val = RISCV_V_VTYPE_RST;
        if (vtype_legal) begin
            vtype_wr_val      = wb.csr_wr_data_vtype_wb;
            vtype_wr_val.vill = 1'b0;
        end
    end

    // An illegal vtype write zeroes vl even if vl is written in the same cycle.
    assign vl_force_zero = wb.csr_wr_en_vtype_wb && !vtype_legal;
    assign vl_wr_val     = (wb.csr_wr_data_vl_wb > VLMAX_ABS) ? VLMAX_ABS : wb.csr_wr_data_vl_wb;
    assign vs_load_val   = riscv_v_vs_state_e'(wb.csr_wr_data_vsstatus_wb[RISCV_V_VS_LSB +: 2]);

    // vstart_clr_wb is deliberately absent: retiring an instruction does not
    // by itself modify architectural vector state.
    assign dirty_ev = wb.csr_wr_en_vtype_wb  || wb.csr_wr_en_vl_wb   ||
                      wb.csr_wr_en_vstart_wb || wb.csr_wr_en_vxrm_wb ||
                      wb.csr_wr_en_vxsat_wb  || wb.vxsat_set_wb      ||
                      wb.vreg_wr_wb;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            vtype_q  <= RISCV_V_VTYPE_RST;
            vl_q     <= '0;
            vstart_q <= '0;
            vxrm_q   <= '0;
            vxsat_q  <= 1'b0;
        end else begin
            if (wb.csr_wr_en_vtype_wb) begin
                vtype_q <= vtype_wr_val;
            end

            if (vl_force_zero) begin
                vl_q <= '0;
            end else if (wb.csr_wr_en_vl_wb) begin
                vl_q <= vl_wr_val;
            end

            if (wb.csr_wr_en_vstart_wb) begin
                vstart_q <= wb.csr_wr_data_vstart_wb;
            end else if (wb.vstart_clr_wb) begin
                vstart_q <= '0;
            end

            if (wb.csr_wr_en_vxrm_wb) begin
                vxrm_q <= wb.csr_wr_data_vxrm_wb;
            end

            if (wb.csr_wr_en_vxsat_wb) begin
                vxsat_q <= wb.csr_wr_data_vxsat_wb;
            end else if (wb.vxsat_set_wb) begin
                vxsat_q <= 1'b1;
            end
        end
    end

    riscv_v_csr_vs_fsm u_vs_fsm (
        .clk      (clk),
        .rst      (rst),
        .load_en  (wb.csr_wr_en_vsstatus_wb),
        .load_val (vs_load_val),
        .dirty_ev (dirty_ev),
        .state    (vs_state)
    );

    // ---------------------------------------------------------------- outputs
`ifdef RISCV_V_CSR_WB_BYPASS_EN
    // Same-cycle read-after-write: forward legalized write data over the
    // registered value while the enable is active.
    always_comb begin
        csr_vtype  = wb.csr_wr_en_vtype_wb ? vtype_wr_val : vtype_q;
        csr_vl     = vl_force_zero ? '0 : (wb.csr_wr_en_vl_wb ? vl_wr_val : vl_q);
        csr_vstart = wb.csr_wr_en_vstart_wb ? wb.csr_wr_data_vstart_wb : vstart_q;
        csr_vxrm   = wb.csr_wr_en_vxrm_wb ? wb.csr_wr_data_vxrm_wb : vxrm_q;
        csr_vxsat  = wb.csr_wr_en_vxsat_wb ? wb.csr_wr_data_vxsat_wb : vxsat_q;
        vs_cur     = wb.csr_wr_en_vsstatus_wb ? vs_load_val : vs_state;
    end
`else
    assign csr_vtype  = vtype_q;
    assign csr_vl     = vl_q;
    assign csr_vstart = vstart_q;
    assign csr_vxrm   = vxrm_q;
    assign csr_vxsat  = vxsat_q;
    assign vs_cur     = vs_state;
`endif

    assign csr_vsstatus = riscv_v_vsstatus_pack(vs_cur);
    assign vs_off       = (vs_cur == OFF);
    assign csr_vcsr     = {csr_vxrm, csr_vxsat};

endmodule

// File: tb/tb_riscv_v_csr.sv
// -----------------------------------------------------------------------------
// tb_riscv_v_csr
// Self-checking bench for riscv_v_csr (default build, registered outputs).
// Each driven cycle updates a behavioural model of the CSR file and queues the
// expected architectural state; a monitor compares the DUT outputs after the
// following clock edge.
// -----------------------------------------------------------------------------
module tb_riscv_v_csr;
    import riscv_v_pkg::*;

    localparam int VLEN  = 128;
    localparam int ELEN  = 32;
    localparam int VLMAX = VLEN / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    riscv_v_csr_if wb ();

    riscv_v_vsstatus_t csr_vsstatus;
    riscv_v_vtype_t    csr_vtype;
    riscv_v_vl_t       csr_vl;
    riscv_v_vstart_t   csr_vstart;
    logic [1:0]        csr_vxrm;
    logic              csr_vxsat;
    logic [2:0]        csr_vcsr;
    logic              vs_off;

    riscv_v_csr #(.VLEN(VLEN), .ELEN(ELEN)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .wb           (wb.slave),
        .csr_vsstatus (csr_vsstatus),
        .csr_vtype    (csr_vtype),
        .csr_vl       (csr_vl),
        .csr_vstart   (csr_vstart),
        .csr_vxrm     (csr_vxrm),
        .csr_vxsat    (csr_vxsat),
        .csr_vcsr     (csr_vcsr),
        .vs_off       (vs_off)
    );

    // Expected architectural state after one clock.
    typedef struct {
        logic [31:0] vtype;
        int          vl;
        int          vstart;
        int          vxrm;
        int          vxsat;
        int          vs;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state, kept as plain fields.
    bit m_vill;
    int m_vma, m_vta, m_vsew, m_vlmul;
    int m_vl, m_vstart, m_vxrm, m_vxsat, m_vs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Legality from the architectural definition: SEW = 8*2^vsew must fit in
    // ELEN, and for LMUL = 1/denom it must also fit in ELEN/denom.
    function automatic bit model_vtype_ok(logic [31:0] d);
        int vsew;
        int vlmul;
        int sew;
        int denom;
        vsew  = int'(d[5:3]);
        vlmul = int'(d[2:0]);
        sew   = 8 * (1 << vsew);
        if (d[30:8] != 0) return 0;
        if (vlmul == 4)   return 0;
        if (sew > ELEN)   return 0;
        if (vlmul >= 5) begin
            denom = 1 << (8 - vlmul);
            if (sew * denom > ELEN) return 0;
        end
        return 1;
    endfunction

    task automatic model_update();
        bit    dirty;
        bit    vt_ok;
        logic [31:0] vt;
        vt = wb.csr_wr_data_vtype_wb;
        if (rst) begin
            m_vill = 1; m_vma = 0; m_vta = 0; m_vsew = 0; m_vlmul = 0;
            m_vl = 0; m_vstart = 0; m_vxrm = 0; m_vxsat = 0; m_vs = 1;
            return;
        end
        dirty = wb.csr_wr_en_vtype_wb || wb.csr_wr_en_vl_wb || wb.csr_wr_en_vstart_wb ||
                wb.csr_wr_en_vxrm_wb || wb.csr_wr_en_vxsat_wb || wb.vxsat_set_wb || wb.vreg_wr_wb;
        vt_ok = model_vtype_ok(vt);
        if (wb.csr_wr_en_vtype_wb) begin
            if (vt_ok) begin
                m_vill = 0; m_vma = int'(vt[7]); m_vta = int'(vt[6]);
                m_vsew = int'(vt[5:3]); m_vlmul = int'(vt[2:0]);
            end else begin
                m_vill = 1; m_vma = 0; m_vta = 0; m_vsew = 0; m_vlmul = 0;
            end
        end
        if (wb.csr_wr_en_vtype_wb && !vt_ok) m_vl = 0;
        else if (wb.csr_wr_en_vl_wb) begin
            m_vl = int'(wb.csr_wr_data_vl_wb);
            if (m_vl > VLMAX) m_vl = VLMAX;
        end
        if (wb.csr_wr_en_vstart_wb) m_vstart = int'(wb.csr_wr_data_vstart_wb) % VLEN;
        else if (wb.vstart_clr_wb)  m_vstart = 0;
        if (wb.csr_wr_en_vxrm_wb) m_vxrm = int'(wb.csr_wr_data_vxrm_wb);
        if (wb.csr_wr_en_vxsat_wb) m_vxsat = int'(wb.csr_wr_data_vxsat_wb);
        else if (wb.vxsat_set_wb)  m_vxsat = 1;
        if (wb.csr_wr_en_vsstatus_wb) m_vs = int'(wb.csr_wr_data_vsstatus_wb[10:9]);
        else if (dirty && m_vs != 0)  m_vs = 3;
    endtask

    task automatic clear_inputs();
        rst                        = 1'b0;
        wb.csr_wr_en_vsstatus_wb   = 1'b0;
        wb.csr_wr_en_vtype_wb      = 1'b0;
        wb.csr_wr_en_vl_wb         = 1'b0;
        wb.csr_wr_en_vstart_wb     = 1'b0;
        wb.csr_wr_en_vxrm_wb       = 1'b0;
        wb.csr_wr_en_vxsat_wb      = 1'b0;
        wb.csr_wr_data_vsstatus_wb = '0;
        wb.csr_wr_data_vtype_wb    = '0;
        wb.csr_wr_data_vl_wb       = '0;
        wb.csr_wr_data_vstart_wb   = '0;
        wb.csr_wr_data_vxrm_wb     = '0;
        wb.csr_wr_data_vxsat_wb    = 1'b0;
        wb.vstart_clr_wb           = 1'b0;
        wb.vxsat_set_wb            = 1'b0;
        wb.vreg_wr_wb              = 1'b0;
    endtask

    // Commit the currently driven inputs: update the model, queue the
    // expectation, clock once, and return with inputs idle at the negedge.
    task automatic step();
        exp_t e;
        model_update();
        e.vtype  = m_vill ? 32'h8000_0000
                          : {24'd0, 1'(m_vma), 1'(m_vta), 3'(m_vsew), 3'(m_vlmul)};
        e.vl     = m_vl;
        e.vstart = m_vstart;
        e.vxrm   = m_vxrm;
        e.vxsat  = m_vxsat;
        e.vs     = m_vs;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
    endtask

    // Monitor: outputs are registered, so each queued expectation is due just
    // after the next rising edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("vtype",    csr_vtype,    e.vtype);
                check("vl",       32'(csr_vl),  32'(e.vl));
                check("vstart",   32'(csr_vstart), 32'(e.vstart));
                check("vxrm",     32'(csr_vxrm), 32'(e.vxrm));
                check("vxsat",    32'(csr_vxsat), 32'(e.vxsat));
                check("vsstatus", csr_vsstatus, 32'(e.vs) << 9);
                check("vs_off",   32'(vs_off),  32'(e.vs == 0));
                check("vcsr",     32'(csr_vcsr), 32'(e.vxrm * 2 + e.vxsat));
            end
        end
    end

    initial begin : stimulus
        logic [31:0] t;
        clear_inputs();

        // 1. Reset, then idle.
        rst = 1'b1; step();
        step();

        // 2. Legal vtype (vsew=010, vlmul=001) with vl=16.
        wb.csr_wr_en_vtype_wb = 1'b1; wb.csr_wr_data_vtype_wb = 32'h0000_0011;
        wb.csr_wr_en_vl_wb = 1'b1; wb.csr_wr_data_vl_wb = 8'd16;
        step();

        // 3. Reserved vlmul=100 with vl=16: vill and vl forced to 0.
        wb.csr_wr_en_vtype_wb = 1'b1; wb.csr_wr_data_vtype_wb = 32'h0000_0004;
        wb.csr_wr_en_vl_wb = 1'b1; wb.csr_wr_data_vl_wb = 8'd16;
        step();

        // Fractional LMUL boundary: SEW=16 at LMUL=1/2 is legal, SEW=32 is not.
        wb.csr_wr_en_vtype_wb = 1'b1; wb.csr_wr_data_vtype_wb = 32'h0000_00CF;
        step();
        wb.csr_wr_en_vtype_wb = 1'b1; wb.csr_wr_data_vtype_wb = 32'h0000_0017;
        step();
        // vsew just above ELEN, then a reserved bit set.
        wb.csr_wr_en_vtype_wb = 1'b1; wb.csr_wr_data_vtype_wb = 32'h0000_0018;
        step();
        wb.csr_wr_en_vtype_wb = 1'b1; wb.csr_wr_data_vtype_wb = 32'h0000_0110;
        step();

        // 4. vl clamp, and the VLMAX boundary from both sides.
        wb.csr_wr_en_vl_wb = 1'b1; wb.csr_wr_data_vl_wb = 8'd200; step();
        wb.csr_wr_en_vl_wb = 1'b1; wb.csr_wr_data_vl_wb = 8'd15;  step();
        wb.csr_wr_en_vl_wb = 1'b1; wb.csr_wr_data_vl_wb = 8'd17;  step();

        // 5. Sticky vxsat and explicit-write priority; vstart priority.
        wb.vxsat_set_wb = 1'b1; step();
        step();
        wb.vxsat_set_wb = 1'b1; wb.csr_wr_en_vxsat_wb = 1'b1; wb.csr_wr_data_vxsat_wb = 1'b0;
        step();
        wb.csr_wr_en_vstart_wb = 1'b1; wb.csr_wr_data_vstart_wb = 7'd5; wb.vstart_clr_wb = 1'b1;
        step();
        wb.vstart_clr_wb = 1'b1; step();
        wb.csr_wr_en_vxrm_wb = 1'b1; wb.csr_wr_data_vxrm_wb = 2'd3; step();

        // 6. VS off ignores dirtying; explicit load beats dirtying; reset wins.
        wb.csr_wr_en_vsstatus_wb = 1'b1; wb.csr_wr_data_vsstatus_wb = 32'h0000_0000; step();
        wb.vreg_wr_wb = 1'b1; step();
        wb.csr_wr_en_vl_wb = 1'b1; wb.csr_wr_data_vl_wb = 8'd3; step();
        wb.csr_wr_en_vsstatus_wb = 1'b1; wb.csr_wr_data_vsstatus_wb = 32'hFFFF_F5FF;
        wb.vreg_wr_wb = 1'b1; step();
        wb.vstart_clr_wb = 1'b1; step();
        rst = 1'b1; wb.csr_wr_en_vtype_wb = 1'b1; wb.csr_wr_data_vtype_wb = 32'h0000_0011;
        wb.csr_wr_en_vl_wb = 1'b1; wb.csr_wr_data_vl_wb = 8'd9; wb.vxsat_set_wb = 1'b1;
        step();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(63) == 0);
            wb.csr_wr_en_vtype_wb = ($urandom_range(3) == 0);
            t = $urandom;
            if ($urandom_range(7) != 0) t[30:8] = '0;
            if ($urandom_range(1) == 1) t[5] = 1'b0;
            wb.csr_wr_data_vtype_wb = t;
            wb.csr_wr_en_vl_wb = ($urandom_range(2) == 0);
            case ($urandom_range(3))
                0: wb.csr_wr_data_vl_wb = 8'(VLMAX);
                1: wb.csr_wr_data_vl_wb = 8'(VLMAX + 1);
                default: wb.csr_wr_data_vl_wb = 8'($urandom_range(255));
            endcase
            wb.csr_wr_en_vstart_wb   = ($urandom_range(4) == 0);
            wb.csr_wr_data_vstart_wb = 7'($urandom);
            wb.csr_wr_en_vxrm_wb     = ($urandom_range(4) == 0);
            wb.csr_wr_data_vxrm_wb   = 2'($urandom);
            wb.csr_wr_en_vxsat_wb    = ($urandom_range(4) == 0);
            wb.csr_wr_data_vxsat_wb  = 1'($urandom);
            wb.csr_wr_en_vsstatus_wb   = ($urandom_range(7) == 0);
            wb.csr_wr_data_vsstatus_wb = $urandom;
            wb.vstart_clr_wb = ($urandom_range(3) == 0);
            wb.vxsat_set_wb  = ($urandom_range(5) == 0);
            wb.vreg_wr_wb    = ($urandom_range(5) == 0);
            step();
        end

        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
